// File: rtl/uart_top.sv
// Full-duplex 8N1 UART: independent transmitter and receiver sharing one clock.
// TX frames a byte on a one-cycle start request; RX deserialises the synchronized line.
module uart_top #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       rs232_in,
    output logic       rs232_tx,
    output logic [7:0] rx_data,
    output logic       tx_done,
    output logic       rx_done
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_WAIT  = 3'd4;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic [1:0]       tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_line_q, tx_line_d;
    logic             tx_end_q, tx_end_d;
    logic             tx_done_q, tx_done_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_end_d   = 1'b0;
        tx_done_d  = tx_end_q;

        // Line is registered from the current state, so it lags the FSM by one cycle
        case (tx_state_q)
            TX_START: tx_line_d = 1'b0;
            TX_DATA:  tx_line_d = tx_shift_q[0];
            default:  tx_line_d = 1'b1;
        endcase

        case (tx_state_q)
            TX_IDLE: begin
                if (start) begin
                    tx_state_d = TX_START;
                    tx_shift_d = data;
                    tx_cnt_d   = '0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = 3'd0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                    tx_end_d   = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tx_line_q  <= 1'b1;
            tx_end_q   <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
            tx_end_q   <= tx_end_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign rs232_tx = tx_line_q;
    assign tx_done  = tx_done_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic             sync1_q, sync2_q, prev_q;
    logic [2:0]       rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_good_q, rx_good_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_done_q, rx_done_d;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_good_d  = 1'b0;
        rx_done_d  = rx_good_q;
        rx_data_d  = rx_good_q ? rx_shift_q : rx_data_q;

        case (rx_state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                // Half a bit in: a line back high means the start edge was a glitch
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {sync2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    if (sync2_q) begin
                        rx_good_d  = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_WAIT;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_WAIT: begin
                if (sync2_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_good_q  <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_done_q  <= 1'b0;
        end else begin
            sync1_q    <= rs232_in;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_good_q  <= rx_good_d;
            rx_data_q  <= rx_data_d;
            rx_done_q  <= rx_done_d;
        end
    end

    assign rx_data = rx_data_q;
    assign rx_done = rx_done_q;

endmodule

// File: tb/tb_uart_top.sv
// Bench for uart_top: a 434-clock instance for exact TX timing and a 16-clock instance
// driven through a scoreboard for framing, loopback, RX error and reset cases.
module tb_uart_top;

    localparam int CA = 434;
    localparam int CB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_a, start_b;
    logic [7:0] data_a, data_b;
    logic       tx_a, tx_b;
    logic [7:0] rx_data_a, rx_data_b;
    logic       tx_done_a, tx_done_b, rx_done_a, rx_done_b;
    logic       rx_drv, loop_en, mon_en;
    logic       rx_in_b;

    assign rx_in_b = loop_en ? tx_b : rx_drv;

    uart_top #(.CLKS_PER_BIT(CA)) dut_a (
        .clk      (clk),
        .rst_n    (rst),
        .start    (start_a),
        .data     (data_a),
        .rs232_in (1'b1),
        .rs232_tx (tx_a),
        .rx_data  (rx_data_a),
        .tx_done  (tx_done_a),
        .rx_done  (rx_done_a)
    );

    uart_top #(.CLKS_PER_BIT(CB)) dut_b (
        .clk      (clk),
        .rst_n    (rst),
        .start    (start_b),
        .data     (data_b),
        .rs232_in (rx_in_b),
        .rs232_tx (tx_b),
        .rx_data  (rx_data_b),
        .tx_done  (tx_done_b),
        .rx_done  (rx_done_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    int tx_cnt = 0;
    int rx_cnt = 0;

    logic [7:0] txq[$];
    logic [7:0] dnq[$];
    logic [7:0] rxq[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic send_b(input logic [7:0] b);
        @(posedge clk);
        #1 start_b = 1'b1;
        data_b = b;
        txq.push_back(b);
        dnq.push_back(b);
        if (loop_en) rxq.push_back(b);
        @(posedge clk);
        #1 start_b = 1'b0;
        data_b = ~b;
    endtask

    task automatic wait_tx_done_b(input string nm);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 12 * CB && !ok; i++) begin
            @(posedge clk);
            #1;
            if (tx_done_b === 1'b1) ok = 1'b1;
        end
        check(nm, {31'd0, ok}, 32'd1);
    endtask

    // Start request raised inside the tx_done cycle of the previous frame
    task automatic send_after_done(input logic [7:0] b);
        wait_tx_done_b("b2b_wait_done");
        start_b = 1'b1;
        data_b = b;
        txq.push_back(b);
        dnq.push_back(b);
        if (loop_en) rxq.push_back(b);
        @(posedge clk);
        #1 start_b = 1'b0;
        data_b = ~b;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        if (stop_bit) rxq.push_back(b);
        for (int k = 0; k < 10; k++) begin
            rx_drv = f[k];
            repeat (CB) @(posedge clk);
            #1;
        end
        rx_drv = 1'b1;
    endtask

    // TX line monitor for dut_b: checks each frame mid-bit against the queued byte
    initial begin : tx_mon
        logic       last;
        logic [7:0] b;
        logic [9:0] f;
        last = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && last === 1'b1 && tx_b === 1'b0) begin
                if (txq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL tx_frame: line went low, required idle high (t=%0t)", $time);
                end else begin
                    b = txq.pop_front();
                    f = {1'b1, b, 1'b0};
                    repeat (CB / 2) @(negedge clk);
                    check("tx_frame_bit0", {31'd0, tx_b}, {31'd0, f[0]});
                    for (int k = 1; k < 10; k++) begin
                        repeat (CB) @(negedge clk);
                        check($sformatf("tx_frame_%02h_bit%0d", b, k), {31'd0, tx_b},
                              {31'd0, f[k]});
                    end
                end
            end
            last = tx_b;
        end
    end

    initial begin : done_mon
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (tx_done_b === 1'b1) begin
                tx_cnt++;
                n_cmp++;
                if (dnq.size() == 0) begin
                    n_err++;
                    $display("FAIL tx_done: pulse seen, required none (t=%0t)", $time);
                end else begin
                    void'(dnq.pop_front());
                end
            end
            if (rx_done_b === 1'b1) begin
                rx_cnt++;
                if (rxq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rx_done: pulse with data %02h, required none (t=%0t)",
                             rx_data_b, $time);
                end else begin
                    e = rxq.pop_front();
                    check("rx_data", {24'd0, rx_data_b}, {24'd0, e});
                end
            end
        end
    end

    initial begin : main
        logic [9:0] fa;
        logic       seen;
        logic       dn_seen;

        rst = 1'b1;
        start_a = 1'b1;
        start_b = 1'b1;
        data_a = 8'hFF;
        data_b = 8'hFF;
        rx_drv = 1'b1;
        loop_en = 1'b0;
        mon_en = 1'b1;

        // Reset held with start high
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_a", {31'd0, tx_a}, 32'd1);
        check("rst_tx_done_a", {31'd0, tx_done_a}, 32'd0);
        check("rst_rx_done_a", {31'd0, rx_done_a}, 32'd0);
        check("rst_rx_data_a", {24'd0, rx_data_a}, 32'h00);
        check("rst_tx_b", {31'd0, tx_b}, 32'd1);
        check("rst_rx_data_b", {24'd0, rx_data_b}, 32'h00);
        rst = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("idle_after_rst_a", {31'd0, tx_a}, 32'd1);
        check("idle_after_rst_b", {31'd0, tx_b}, 32'd1);

        // 8'h55 at 434 clocks per bit, checked every cycle
        @(posedge clk);
        #1 start_a = 1'b1;
        data_a = 8'h55;
        @(posedge clk);
        #1 start_a = 1'b0;
        data_a = 8'h00;
        check("tx_a_before_start_bit", {31'd0, tx_a}, 32'd1);
        fa = 10'b1_0101_0101_0;
        dn_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            seen = fa[k];
            for (int c = 0; c < CA; c++) begin
                @(posedge clk);
                #1;
                if (tx_a !== fa[k]) seen = tx_a;
                if (tx_done_a !== 1'b0) dn_seen = 1'b1;
            end
            check($sformatf("tx55_bit%0d", k), {31'd0, seen}, {31'd0, fa[k]});
        end
        check("tx55_no_early_done", {31'd0, dn_seen}, 32'd0);
        @(posedge clk);
        #1;
        check("tx55_done_pulse", {31'd0, tx_done_a}, 32'd1);
        check("tx55_idle_line", {31'd0, tx_a}, 32'd1);
        @(posedge clk);
        #1;
        check("tx55_done_single", {31'd0, tx_done_a}, 32'd0);

        // Busy ignore: second start mid-frame must not produce a frame
        send_b(8'hA3);
        repeat (3 * CB) @(posedge clk);
        #1 start_b = 1'b1;
        data_b = 8'hFF;
        @(posedge clk);
        #1 start_b = 1'b0;
        wait_tx_done_b("busy_wait_done");
        repeat (12 * CB) @(posedge clk);
        #1;
        check("busy_tx_done_count", tx_cnt, 32'd1);

        // Loopback, back to back
        loop_en = 1'b1;
        send_b(8'h00);
        send_after_done(8'hFF);
        send_after_done(8'hA5);
        wait_tx_done_b("loop_wait_done");
        repeat (2 * CB) @(posedge clk);
        #1;
        check("loop_rx_count", rx_cnt, 32'd3);
        check("loop_rx_last", {24'd0, rx_data_b}, 32'hA5);
        check("loop_tx_count", tx_cnt, 32'd4);
        loop_en = 1'b0;

        // Short low glitch
        repeat (4) begin
            @(posedge clk);
            #1 rx_drv = 1'b0;
        end
        @(posedge clk);
        #1 rx_drv = 1'b1;
        repeat (3 * CB) @(posedge clk);
        #1;
        check("glitch_no_rx", rx_cnt, 32'd3);

        // Framing error, then a good frame
        send_rx(8'h5A, 1'b0);
        repeat (2 * CB) @(posedge clk);
        #1;
        check("frame_err_no_rx", rx_cnt, 32'd3);
        check("frame_err_data_kept", {24'd0, rx_data_b}, 32'hA5);
        send_rx(8'h3C, 1'b1);
        repeat (2 * CB) @(posedge clk);
        #1;
        check("good_after_err_count", rx_cnt, 32'd4);
        check("good_after_err_data", {24'd0, rx_data_b}, 32'h3C);

        // Reset during data bit 3 of 8'hC6 (bit 3 is 0)
        mon_en = 1'b0;
        @(posedge clk);
        #1 start_b = 1'b1;
        data_b = 8'hC6;
        @(posedge clk);
        #1 start_b = 1'b0;
        repeat (4 * CB + CB / 2) @(posedge clk);
        #1;
        check("mid_tx_bit3_low", {31'd0, tx_b}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_tx_rst_line_high", {31'd0, tx_b}, 32'd1);
        rst = 1'b0;
        repeat (12 * CB) @(posedge clk);
        #1;
        check("mid_tx_rst_no_done", tx_cnt, 32'd4);
        check("mid_tx_rst_line_idle", {31'd0, tx_b}, 32'd1);
        mon_en = 1'b1;
        send_b(8'hC6);
        wait_tx_done_b("post_rst_wait_done");
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_tx_count", tx_cnt, 32'd5);

        check("txq_drained", txq.size(), 32'd0);
        check("dnq_drained", dnq.size(), 32'd0);
        check("rxq_drained", rxq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_top.md
# uart_top

Full-duplex 8N1 UART with one transmitter and one receiver sharing a single clock domain, used as the serial front end between the core logic and an external RS-232 line. The transmitter serialises a byte on a one-cycle `start` request. The receiver deserialises bytes arriving on `rs232_in`. Each direction reports completion with a one-cycle done pulse.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit; 50 MHz / 115200 baud. Legal range is ≥ 4, even values only.
- `clk`  input  1  system clock; all logic is rising-edge.
- `rst_n`  input  1  synchronous, active-high reset (1 = reset), sampled on `clk`.
- `start`  input  1  transmit request; accepted only while TX is idle.
- `data`  input  8  byte to transmit; sampled in the cycle `start` is accepted.
- `rs232_in`  input  1  asynchronous serial receive line; idle high.
- `rs232_tx`  output  1  serial transmit line; idle high.
- `rx_data`  output  8  last correctly framed received byte; holds its value until the next good frame.
- `tx_done`  output  1  one-cycle pulse when a transmit frame completes.
- `rx_done`  output  1  one-cycle pulse when `rx_data` is updated.

## Operation
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- TX FSM states: IDLE → START → DATA(8 bits) → STOP → IDLE.
  - IDLE: `rs232_tx` = 1. If `start` = 1, latch `data` into a shift register and go to START.
  - Each of START, DATA and STOP holds its line value for exactly `CLKS_PER_BIT` cycles.
  - `start` asserted while not IDLE is ignored; no queueing.
  - Changes on `data` after acceptance have no effect on the frame in flight.
- RX front end: `rs232_in` passes through a 2-flop synchronizer, preset to 1 on reset. The FSM uses only the synchronized signal.
- RX FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a 1→0 transition on the synchronized line enters START.
  - START: at `CLKS_PER_BIT/2` cycles, re-check the line. If it is 1, treat it as a glitch and return to IDLE. If it is 0, go to DATA.
  - DATA: sample one bit every `CLKS_PER_BIT` cycles (mid-bit) into a shift register, LSB first, 8 bits total.
  - STOP: sample mid-bit. If the sample is 1, load `rx_data` and pulse `rx_done`. If it is 0 (framing error), discard the byte with no pulse and no `rx_data` change, then wait for the line to return to 1 before going to IDLE.
- TX and RX are fully independent and may run simultaneously. External loopback (`rs232_in` = `rs232_tx`) must return the transmitted byte.

## Timing
- Reset values:
  - `rs232_tx` = 1, `tx_done` = 0, `rx_done` = 0, `rx_data` = 8'h00.
  - Both FSMs in IDLE, all counters 0, synchronizer flops = 1.
- Reset asserted mid-frame aborts immediately. `rs232_tx` is 1 on the next cycle and no done pulse is generated.
- TX latency:
  - `start` is sampled high at edge N. `rs232_tx` = 0 from edge N+1.
  - Data bit k begins at edge N+1+(k+1)·`CLKS_PER_BIT`.
  - Stop bit begins at N+1+9·`CLKS_PER_BIT`.
  - `tx_done` = 1 for the single cycle following edge N+1+10·`CLKS_PER_BIT`, when the FSM is back in IDLE.
- Back-to-back TX: `start` high during the `tx_done` cycle is accepted. Frames then abut with no idle gap.
- RX latency:
  - A falling edge seen by the synchronizer at edge M is detected at M+2.
  - Data bit k is sampled at M+2+`CLKS_PER_BIT`/2+(k+1)·`CLKS_PER_BIT`.
  - `rx_data` updates and `rx_done` = 1 for one cycle, on the edge after the stop-bit sample.
- `rx_done` and `tx_done` may pulse in the same cycle.

## Test plan
- Reset: hold `rst_n` = 1 for 3 cycles with `start` = 1 → `rs232_tx` = 1, both done = 0, `rx_data` = 8'h00. No frame starts until reset is released and a new `start` sample is taken.
- TX 8'h55, `CLKS_PER_BIT` = 434, 50 MHz:
  - Pulse `start` for 1 cycle.
  - Required line sequence: 0,1,0,1,0,1,0,1,0,1, each bit 8.68 µs.
  - Then exactly one `tx_done` pulse 4340 cycles after the frame starts.
- Busy ignore (`CLKS_PER_BIT` = 16): send 8'hA3, then pulse `start` with `data` = 8'hFF mid-frame → only the 8'hA3 frame appears on the line, and only one `tx_done` pulse.
- Loopback (`CLKS_PER_BIT` = 16): tie `rs232_in` to `rs232_tx` and send 8'h00, 8'hFF, 8'hA5 back to back → `rx_data` = 00, FF, A5 in order, with one `rx_done` per byte.
- RX errors (`CLKS_PER_BIT` = 16):
  - A 4-cycle low glitch on `rs232_in` → no `rx_done`.
  - A frame with the stop bit forced to 0 → no `rx_done` and `rx_data` unchanged.
  - A following good frame 8'h3C is received correctly.
- Reset mid-TX: assert `rst_n` during data bit 3 → `rs232_tx` = 1 on the next cycle and no `tx_done`. A subsequent `start` sends a full, correct frame.
